// File: rtl/adder_share_arbiter.sv
// Round-robin sequencer sharing one external adder among NUM_REQ requesters.
// Optional signed-overflow output enabled by defining ADDER_SHARE_ARB_OVF_EN.
//
// state | meaning
// IDLE  | no transaction in flight, grant any pending request
// CALC  | adder inputs stable for one cycle, result captured at the edge
// RESP  | response held until rsp_ready, may grant the next request same cycle
module adder_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_cin,
  output logic [WIDTH-1:0]         add_in1,
  output logic [WIDTH-1:0]         add_in2,
  output logic                     add_cin,
  input  logic [WIDTH-1:0]         add_sum,
  input  logic                     add_cout,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout,
  output logic                     busy
`ifdef ADDER_SHARE_ARB_OVF_EN
  ,
  output logic                     rsp_ovf
`endif
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] id_q;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] cand;
  logic            any_valid;
  logic            grant;
  int              sel;

  // Descending scan so the requester closest to rr_ptr is the last to assign.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    cand      = '0;
    sel       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sel = int'(rr_ptr) + k;
      if (sel >= NUM_REQ) sel = sel - NUM_REQ;
      cand = ID_W'(sel);
      if (req_valid[cand]) begin
        winner    = cand;
        any_valid = 1'b1;
      end
    end
  end

  assign grant     = rst_n & any_valid &
                     ((state == IDLE) | ((state == RESP) & rsp_ready));
  assign req_ready = grant ? (NUM_REQ'(1) << winner) : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (any_valid) state_nxt = CALC;
      CALC: state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = any_valid ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      id_q      <= '0;
      add_in1   <= '0;
      add_in2   <= '0;
      add_cin   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
    end else begin
      if (grant) begin
        add_in1 <= req_a[winner*WIDTH +: WIDTH];
        add_in2 <= req_b[winner*WIDTH +: WIDTH];
        add_cin <= req_cin[winner];
        id_q    <= winner;
        rr_ptr  <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      end
      if (state == CALC) begin
        rsp_sum   <= add_sum;
        rsp_cout  <= add_cout;
        rsp_id    <= id_q;
        rsp_valid <= 1'b1;
      end else if ((state == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ADDER_SHARE_ARB_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_ovf <= 1'b0;
    end else if (state == CALC) begin
      rsp_ovf <= (add_in1[WIDTH-1] == add_in2[WIDTH-1]) &
                 (add_sum[WIDTH-1] != add_in1[WIDTH-1]);
    end
  end
`endif

endmodule
